// File: rtl/pid_reg_bank_pkg.sv
// Purpose: register map, reset values and status layout shared by the PID register bank.
// Latency: n/a (constants and types only).
// Backpressure: n/a.
package pid_reg_pkg;

  // Register index map
  localparam logic [7:0] ADDR_KP_L    = 8'h40;
  localparam logic [7:0] ADDR_KP_H    = 8'h41;
  localparam logic [7:0] ADDR_KI_L    = 8'h42;
  localparam logic [7:0] ADDR_KI_H    = 8'h43;
  localparam logic [7:0] ADDR_KD_L    = 8'h44;
  localparam logic [7:0] ADDR_KD_H    = 8'h45;
  localparam logic [7:0] ADDR_SP_L    = 8'h46;
  localparam logic [7:0] ADDR_SP_H    = 8'h47;
  localparam logic [7:0] ADDR_LIM_L   = 8'h48;
  localparam logic [7:0] ADDR_LIM_H   = 8'h49;
  localparam logic [7:0] ADDR_CTRL    = 8'h4A;
  localparam logic [7:0] ADDR_COMMIT  = 8'h4B;
  localparam logic [7:0] ADDR_SPD_L   = 8'h4C;
  localparam logic [7:0] ADDR_SPD_H   = 8'h4D;
  localparam logic [7:0] ADDR_DUTY_L  = 8'h4E;
  localparam logic [7:0] ADDR_DUTY_H  = 8'h4F;
  localparam logic [7:0] ADDR_STATUS  = 8'h50;
  localparam logic [7:0] ADDR_ERR     = 8'h51;
  localparam logic [7:0] ADDR_SCRATCH = 8'h52;
  localparam logic [7:0] ADDR_ID      = 8'h53;

  // Reset values of the configuration (shadow and active copies)
  localparam logic [15:0] KP_RST  = 16'h0100;
  localparam logic [15:0] KI_RST  = 16'h0000;
  localparam logic [15:0] KD_RST  = 16'h0000;
  localparam logic [15:0] SP_RST  = 16'h0000;
  localparam logic [15:0] LIM_RST = 16'hFFFF;
  localparam logic [7:0]  CTRL_RST = 8'h00;

  // Status byte layout: [3:0] sticky faults, [4] commit pending, [5] active enable
  localparam int STAT_FAULT_W  = 4;
  localparam int STAT_PEND_BIT = 4;
  localparam int STAT_EN_BIT   = 5;

  typedef struct packed {
    logic [15:0] kp;
    logic [15:0] ki;
    logic [15:0] kd;
    logic [15:0] setpoint;
    logic [15:0] out_limit;
    logic [7:0]  ctrl;
  } cfg_t;

  localparam cfg_t CFG_RST = '{kp: KP_RST, ki: KI_RST, kd: KD_RST,
                               setpoint: SP_RST, out_limit: LIM_RST, ctrl: CTRL_RST};

endpackage

// File: rtl/pid_reg_bank_strobe_edge.sv
// Purpose: 1-bit rising-edge detector for slave request levels (clk, rst, lvl in; rise out).
// Latency: rise is combinational in the cycle lvl first goes high.
// Backpressure: none; a held level yields exactly one rise.
module strobe_edge (
  input  logic clk,
  input  logic rst,
  input  logic lvl,
  output logic rise
);

  logic lvl_q;
  logic lvl_d;

  always_comb begin
    lvl_d = lvl;
  end

  // History clears to 0 so a level held through reset release reads as a new edge.
  always_ff @(posedge clk) begin
    if (rst) lvl_q <= 1'b0;
    else     lvl_q <= lvl_d;
  end

  assign rise = lvl & ~lvl_q;

endmodule

// File: rtl/pid_reg_bank.sv
// Purpose: I2C-facing register bank for the BLDC PID: shadow config with atomic commit,
//          telemetry snapshots, sticky faults, saturating error count.
//          Ports: clk/rst, wr_req/rd_req/index/wdata/rdata slave side, i2c_busy,
//          speed_meas/pwm_duty/fault_in telemetry in, kp/ki/kd/setpoint/out_limit/ctrl/commit_pulse out.
// Latency: rdata one cycle after index; shadow write one cycle after wr_req edge; commit >= 2 cycles.
// Backpressure: none; a commit waits while i2c_busy is high.
module pid_reg_bank
  import pid_reg_pkg::*;
#(
  parameter logic [7:0] BASE_ADDR  = 8'h40,
  parameter logic [7:0] LAST_ADDR  = 8'h53,
  parameter logic [7:0] COMMIT_KEY = 8'hA5,
  parameter logic [7:0] DEVICE_ID  = 8'h72
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wr_req,
  input  logic        rd_req,
  input  logic [7:0]  index,
  input  logic [7:0]  wdata,
  output logic [7:0]  rdata,
  input  logic        i2c_busy,
  input  logic [15:0] speed_meas,
  input  logic [15:0] pwm_duty,
  input  logic [3:0]  fault_in,
  output logic [15:0] kp,
  output logic [15:0] ki,
  output logic [15:0] kd,
  output logic [15:0] setpoint,
  output logic [15:0] out_limit,
  output logic [7:0]  ctrl,
  output logic        commit_pulse
);

  logic wr_rise;
  logic rd_rise;

  strobe_edge u_wr_edge (.clk(clk), .rst(rst), .lvl(wr_req), .rise(wr_rise));
  strobe_edge u_rd_edge (.clk(clk), .rst(rst), .lvl(rd_req), .rise(rd_rise));

  cfg_t        shadow_q, shadow_d;
  cfg_t        active_q, active_d;
  logic [7:0]  scratch_q, scratch_d;
  logic [3:0]  faults_q, faults_d;
  logic        pending_q, pending_d;
  logic [7:0]  err_q, err_d;
  logic [15:0] snap_speed_q, snap_speed_d;
  logic [15:0] snap_duty_q, snap_duty_d;
  logic [7:0]  index_prev_q, index_prev_d;
  logic [7:0]  rdata_q, rdata_d;
  logic        commit_pulse_q, commit_pulse_d;

  logic        in_range;
  logic        key_ok;
  logic        wr_err;
  logic        rd_err;
  logic        do_commit;
  logic        index_chg;
  logic [7:0]  status;

  always_comb begin
    shadow_d     = shadow_q;
    scratch_d    = scratch_q;
    key_ok       = 1'b0;
    wr_err       = 1'b0;
    in_range     = (index >= BASE_ADDR) && (index <= LAST_ADDR);
    rd_err       = rd_rise && !in_range;

    if (wr_rise) begin
      if (!in_range) begin
        wr_err = 1'b1;
      end else begin
        case (index)
          ADDR_KP_L:    shadow_d.kp[7:0]         = wdata;
          ADDR_KP_H:    shadow_d.kp[15:8]        = wdata;
          ADDR_KI_L:    shadow_d.ki[7:0]         = wdata;
          ADDR_KI_H:    shadow_d.ki[15:8]        = wdata;
          ADDR_KD_L:    shadow_d.kd[7:0]         = wdata;
          ADDR_KD_H:    shadow_d.kd[15:8]        = wdata;
          ADDR_SP_L:    shadow_d.setpoint[7:0]   = wdata;
          ADDR_SP_H:    shadow_d.setpoint[15:8]  = wdata;
          ADDR_LIM_L:   shadow_d.out_limit[7:0]  = wdata;
          ADDR_LIM_H:   shadow_d.out_limit[15:8] = wdata;
          ADDR_CTRL:    shadow_d.ctrl            = wdata;
          ADDR_COMMIT: begin
            if (wdata == COMMIT_KEY) key_ok = 1'b1;
            else                     wr_err = 1'b1;
          end
          ADDR_SCRATCH: scratch_d = wdata;
          // Snapshots, status, err_count and device id are read-only.
          default:      wr_err = 1'b1;
        endcase
      end
    end

    // Commit copies the pre-write shadow; a key landing on the commit cycle re-arms.
    do_commit      = pending_q && !i2c_busy;
    active_d       = do_commit ? shadow_q : active_q;
    commit_pulse_d = do_commit;
    pending_d      = key_ok | (pending_q & ~do_commit);

    // Clear-on-read of the fault bits; a fault arriving the same cycle survives.
    faults_d = ((rd_rise && index == ADDR_STATUS) ? 4'h0 : faults_q) | fault_in;

    err_d = ((wr_err || rd_err) && err_q != 8'hFF) ? err_q + 8'd1 : err_q;

    // Snapshots latch only when the index moves onto the low byte, so lo/hi are coherent.
    index_prev_d = index;
    index_chg    = (index != index_prev_q);
    snap_speed_d = (index_chg && index == ADDR_SPD_L)  ? speed_meas : snap_speed_q;
    snap_duty_d  = (index_chg && index == ADDR_DUTY_L) ? pwm_duty   : snap_duty_q;

    status                          = 8'h00;
    status[STAT_FAULT_W-1:0]        = faults_q;
    status[STAT_PEND_BIT]           = pending_q;
    status[STAT_EN_BIT]             = active_q.ctrl[0];

    // The _d snapshot is used so a read on the latching cycle returns the fresh value.
    case (index)
      ADDR_KP_L:    rdata_d = shadow_q.kp[7:0];
      ADDR_KP_H:    rdata_d = shadow_q.kp[15:8];
      ADDR_KI_L:    rdata_d = shadow_q.ki[7:0];
      ADDR_KI_H:    rdata_d = shadow_q.ki[15:8];
      ADDR_KD_L:    rdata_d = shadow_q.kd[7:0];
      ADDR_KD_H:    rdata_d = shadow_q.kd[15:8];
      ADDR_SP_L:    rdata_d = shadow_q.setpoint[7:0];
      ADDR_SP_H:    rdata_d = shadow_q.setpoint[15:8];
      ADDR_LIM_L:   rdata_d = shadow_q.out_limit[7:0];
      ADDR_LIM_H:   rdata_d = shadow_q.out_limit[15:8];
      ADDR_CTRL:    rdata_d = shadow_q.ctrl;
      ADDR_SPD_L:   rdata_d = snap_speed_d[7:0];
      ADDR_SPD_H:   rdata_d = snap_speed_d[15:8];
      ADDR_DUTY_L:  rdata_d = snap_duty_d[7:0];
      ADDR_DUTY_H:  rdata_d = snap_duty_d[15:8];
      ADDR_STATUS:  rdata_d = status;
      ADDR_ERR:     rdata_d = err_q;
      ADDR_SCRATCH: rdata_d = scratch_q;
      ADDR_ID:      rdata_d = DEVICE_ID;
      default:      rdata_d = 8'h00;  // commit register and out-of-range
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      shadow_q       <= CFG_RST;
      active_q       <= CFG_RST;
      scratch_q      <= 8'h00;
      faults_q       <= 4'h0;
      pending_q      <= 1'b0;
      err_q          <= 8'h00;
      snap_speed_q   <= 16'h0000;
      snap_duty_q    <= 16'h0000;
      index_prev_q   <= 8'h00;
      rdata_q        <= 8'h00;
      commit_pulse_q <= 1'b0;
    end else begin
      shadow_q       <= shadow_d;
      active_q       <= active_d;
      scratch_q      <= scratch_d;
      faults_q       <= faults_d;
      pending_q      <= pending_d;
      err_q          <= err_d;
      snap_speed_q   <= snap_speed_d;
      snap_duty_q    <= snap_duty_d;
      index_prev_q   <= index_prev_d;
      rdata_q        <= rdata_d;
      commit_pulse_q <= commit_pulse_d;
    end
  end

  assign kp           = active_q.kp;
  assign ki           = active_q.ki;
  assign kd           = active_q.kd;
  assign setpoint     = active_q.setpoint;
  assign out_limit    = active_q.out_limit;
  assign ctrl         = active_q.ctrl;
  assign rdata        = rdata_q;
  assign commit_pulse = commit_pulse_q;

endmodule
